// File: rtl/sr_button_conditioner.sv
// Debounced set/reset pushbutton front end that issues fixed-width, mutually
// exclusive S/R command pulses to a downstream SR latch.

module sr_debounce_channel #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic stable,
    output logic press
);
    localparam logic [15:0] CNT_TC = 16'(DB_CYCLES - 1);

    logic        sync1;
    logic        sync2;
    logic        stable_d;
    logic [15:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            stable_d <= stable;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_TC) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    // Rising edge of the debounced level only; releases are silent.
    assign press = stable & ~stable_d;
endmodule

// state    | meaning
// IDLE     | waiting for a press event; resolves set/reset/conflict
// PULSE_S  | driving S for PULSE_CYCLES clocks
// PULSE_R  | driving R for PULSE_CYCLES clocks
// WAIT_REL | pulse done, waiting for both debounced buttons to be released
module sr_button_conditioner #(
    parameter int DB_CYCLES    = 4,
    parameter int PULSE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_s,
    input  logic btn_r,
    output logic S,
    output logic R,
    output logic conflict,
    output logic busy
);
    localparam logic [7:0] PULSE_TC = 8'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PULSE_S  = 2'd1,
        PULSE_R  = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] pcnt;
    logic [7:0] pcnt_next;
    logic       s_next;
    logic       r_next;
    logic       conflict_next;
    logic       busy_next;

    logic stable_s;
    logic stable_r;
    logic press_s;
    logic press_r;

    sr_debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_ch_s (
        .clk    (clk),
        .rst    (rst),
        .btn    (btn_s),
        .stable (stable_s),
        .press  (press_s)
    );

    sr_debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_ch_r (
        .clk    (clk),
        .rst    (rst),
        .btn    (btn_r),
        .stable (stable_r),
        .press  (press_r)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pcnt     <= '0;
            S        <= 1'b0;
            R        <= 1'b0;
            conflict <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            pcnt     <= pcnt_next;
            S        <= s_next;
            R        <= r_next;
            conflict <= conflict_next;
            busy     <= busy_next;
        end
    end

    // Outputs are the registered image of the next state, so S/R/busy line up
    // with the state they belong to and no input reaches a port combinationally.
    always_comb begin
        state_next    = state;
        pcnt_next     = pcnt;
        s_next        = 1'b0;
        r_next        = 1'b0;
        conflict_next = 1'b0;
        unique case (state)
            IDLE: begin
                if (press_s && press_r) begin
                    conflict_next = 1'b1;
                end else if (press_s) begin
                    state_next = PULSE_S;
                    pcnt_next  = PULSE_TC;
                    s_next     = 1'b1;
                end else if (press_r) begin
                    state_next = PULSE_R;
                    pcnt_next  = PULSE_TC;
                    r_next     = 1'b1;
                end
            end
            PULSE_S: begin
                if (pcnt == 8'd0) begin
                    state_next = WAIT_REL;
                end else begin
                    pcnt_next = pcnt - 8'd1;
                    s_next    = 1'b1;
                end
            end
            PULSE_R: begin
                if (pcnt == 8'd0) begin
                    state_next = WAIT_REL;
                end else begin
                    pcnt_next = pcnt - 8'd1;
                    r_next    = 1'b1;
                end
            end
            WAIT_REL: begin
                if (!stable_s && !stable_r) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end
endmodule

// File: tb/tb_sr_button_conditioner.sv
// Directed bench for sr_button_conditioner at default parameters: vector table
// plus hand-written reset and press-during-pulse sequences.

module tb_sr_button_conditioner;
    logic clk = 1'b0;
    logic rst;
    logic btn_s;
    logic btn_r;
    logic S;
    logic R;
    logic conflict;
    logic busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic bs;
        logic br;
        logic s;
        logic r;
        logic c;
        logic b;
    } vec_t;

    vec_t tbl[$];

    sr_button_conditioner #(.DB_CYCLES(4), .PULSE_CYCLES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_s    (btn_s),
        .btn_r    (btn_r),
        .S        (S),
        .R        (R),
        .conflict (conflict),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b", name, act, exp);
        end
    endtask

    always @(negedge clk) check("s_r_exclusive", S & R, 1'b0);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic bs, input logic br, input logic s,
                       input logic r, input logic c, input logic b);
        vec_t v;
        v.bs = bs; v.br = br; v.s = s; v.r = r; v.c = c; v.b = b;
        tbl.push_back(v);
    endtask

    task automatic check_outs(input string tag, input logic s, input logic r,
                              input logic c, input logic b);
        check({tag, "_S"}, S, s);
        check({tag, "_R"}, R, r);
        check({tag, "_conflict"}, conflict, c);
        check({tag, "_busy"}, busy, b);
    endtask

    initial begin
        // Clean set press: held 20 cycles; S on after edges k+6,k+7;
        // stable_s falls after k+25 so WAIT_REL exits at k+26.
        for (int j = 0; j < 30; j++)
            add(j < 20, 1'b0, (j == 6 || j == 7), 1'b0, 1'b0, (j >= 6 && j < 26));
        // Simultaneous press: one-cycle conflict after k+6, never busy.
        for (int j = 0; j < 20; j++)
            add(j < 12, j < 12, 1'b0, 1'b0, (j == 6), 1'b0);
        // Bounce 1,0,1,0 then quiet: nothing may happen.
        for (int j = 0; j < 12; j++)
            add((j == 0 || j == 2), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Clean reset press for the R path.
        for (int j = 0; j < 28; j++)
            add(1'b0, j < 10, 1'b0, (j == 6 || j == 7), 1'b0, (j >= 6 && j < 16));

        rst   = 1'b1;
        btn_s = 1'b0;
        btn_r = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (3) step();
        check_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        foreach (tbl[i]) begin
            btn_s = tbl[i].bs;
            btn_r = tbl[i].br;
            step();
            check_outs($sformatf("vec%0d", i), tbl[i].s, tbl[i].r, tbl[i].c, tbl[i].b);
        end

        // Press during pulse: R arrives 2 cycles after S and must be dropped.
        for (int j = 0; j < 16; j++) begin
            btn_s = 1'b1;
            btn_r = (j >= 2);
            step();
            check_outs($sformatf("overlap%0d", j), (j == 6 || j == 7), 1'b0, 1'b0, (j >= 6));
        end
        btn_s = 1'b0;
        btn_r = 1'b0;
        repeat (12) step();
        check_outs("overlap_released", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 9; j++) begin
            btn_r = 1'b1;
            step();
            check_outs($sformatf("fresh_r%0d", j), 1'b0, (j == 6 || j == 7), 1'b0, (j >= 6));
        end
        btn_r = 1'b0;
        repeat (12) step();
        check_outs("fresh_r_released", 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-pulse, button held through reset release.
        btn_s = 1'b1;
        repeat (7) step();
        check("midpulse_S_before_rst", S, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_outs("midpulse_async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outs("midpulse_in_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int j = 0; j < 9; j++) begin
            step();
            check_outs($sformatf("after_rst%0d", j), (j == 6 || j == 7), 1'b0, 1'b0, (j >= 6));
        end
        btn_s = 1'b0;
        repeat (12) step();
        check_outs("final_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sr_button_conditioner.md
SR_BUTTON_CONDITIONER -- requirements
Module: sr_button_conditioner

Interface
REQ-001 Parameter DB_CYCLES, default 4, SHALL set the consecutive stable cycles required to accept a level change on each button (legal range 2..65535).
REQ-002 Parameter PULSE_CYCLES, default 2, SHALL set the width in clocks of each S or R command pulse (legal range 1..255).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 btn_s  input  1  SHALL be the raw, asynchronous, bouncing set pushbutton (1 = pressed).
REQ-006 btn_r  input  1  SHALL be the raw, asynchronous, bouncing reset pushbutton (1 = pressed).
REQ-007 S  output  1  SHALL be the registered set command to the downstream SR latch S input.
REQ-008 R  output  1  SHALL be the registered reset command to the downstream SR latch R input.
REQ-009 conflict  output  1  SHALL be a registered one-cycle flag for simultaneous set/reset presses.
REQ-010 busy  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-011 Each button SHALL pass through its own 2-flop synchronizer (sync1, sync2); no raw input SHALL reach other logic.
REQ-012 Each channel SHALL hold a debounced level `stable` and a 16-bit counter `cnt`, updated per edge as follows: sync2 == stable -> cnt cleared; otherwise, cnt == DB_CYCLES-1 -> stable takes sync2 and cnt clears; otherwise cnt increments.
REQ-013 A press event SHALL be high for exactly the one cycle after stable changes 0->1; a 1->0 change SHALL produce no event.
REQ-014 The FSM SHALL have states IDLE, PULSE_S, PULSE_R and WAIT_REL, plus an 8-bit pulse counter.
REQ-015 IDLE SHALL resolve press events as follows:
- press_s and press_r together -> conflict=1 for one cycle, remain IDLE.
- press_s only -> PULSE_S.
- press_r only -> PULSE_R.
- none -> remain IDLE.
REQ-016 PULSE_S SHALL drive S=1 for exactly PULSE_CYCLES cycles, then enter WAIT_REL; PULSE_R SHALL do the same with R.
REQ-017 WAIT_REL SHALL remain until both stable levels are 0, then enter IDLE on the next edge.
REQ-018 Press events arriving outside IDLE SHALL be discarded, not queued.
REQ-019 S and R SHALL never both be 1 in any cycle, including across reset.
REQ-020 Latency: with btn_s first sampled high at edge k and held, S SHALL rise after edge k+DB_CYCLES+2 (edge k+6 at defaults).
REQ-021 Bounces shorter than DB_CYCLES consecutive cycles SHALL leave stable unchanged and produce no event.
REQ-022 S, R, conflict and busy SHALL be driven directly from flops; no combinational path SHALL run from any input to any output.

Reset
REQ-023 Asserting rst SHALL immediately force, independent of clk:
- S=0, R=0, conflict=0, busy=0.
- FSM to IDLE.
- all synchronizer flops, stable levels and counters to 0.
REQ-024 Reset asserted mid-pulse SHALL truncate the pulse at once, and no pulse SHALL resume after release.
REQ-025 A button held through reset release SHALL be treated as a new press once it has debounced.

Verification
REQ-026 Clean set press, defaults: btn_s 0->1 held 20 cycles -> S=1 for 2 cycles starting after edge k+6, R stays 0, busy held until stable_s returns to 0.
REQ-027 Bounce rejection: btn_s toggling 1,0,1,0 at one-cycle intervals, then 0 -> S, R and conflict stay 0; both stable levels stay 0.
REQ-028 Simultaneous press: btn_s and btn_r rise on the same edge and are held -> conflict=1 for exactly one cycle, S=R=0, busy=0.
REQ-029 Press during pulse: btn_r pressed 2 cycles after btn_s (both held) -> only the S pulse occurs; the R event is discarded; after both releases, a fresh btn_r press -> R=1 for 2 cycles.
REQ-030 Reset mid-pulse: rst asserted during the first S=1 cycle -> S=0 before the next clk edge; after release with btn_s still held -> a new S pulse after DB_CYCLES+2 edges.
REQ-031 Continuous assertion: S&R == 0 checked on every cycle of every scenario.
